div_iter_ctrl: RTL

DIV_ITER_CTRL -- requirements
Module: div_iter_ctrl

---
 rtl/div_iter_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/div_iter_ctrl.sv
// Iterative restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready + dividend/divisor,
//        out_valid/out_ready + quotient/remainder/div_zero (registered results).
module div_iter_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_zero
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // shift_q starts as the dividend; each step shifts its MSB out into the
    // partial remainder and the new quotient bit in at the LSB, so after W
    // steps it holds the full quotient.
    logic [W-1:0]  shift_q;
    logic [W-1:0]  dsr_q;
    logic [W-1:0]  rem_q;
    logic [CW-1:0] cnt_q;

    logic          accept;
    logic          last_step;
    logic          ge;
    logic [W-1:0]  trial;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  shift_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q == LAST);

    // Before the final step the partial remainder is below 2^(W-1), so
    // dropping its MSB in the shift never loses information.
    assign trial     = {rem_q[W-2:0], shift_q[W-1]};
    assign ge        = (trial >= dsr_q);
    assign rem_nxt   = ge ? (trial - dsr_q) : trial;
    assign shift_nxt = {shift_q[W-2:0], ge};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                        end else begin
                            shift_q <= dividend;
                            dsr_q   <= divisor;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                        end
                    end
                end
                CALC: begin
                    shift_q <= shift_nxt;
                    rem_q   <= rem_nxt;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_step) begin
                        quotient  <= shift_nxt;
                        remainder <= rem_nxt;
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
